// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx - PS/2 keyboard receiver with deglitch, frame timeout,
// E0/F0 prefix folding, event FIFO and error/overflow status.
//
// Ports:
//   clk         system clock (only clock)
//   clrn        asynchronous active-low reset
//   ps2_clk     raw PS/2 clock pin (asynchronous)
//   ps2_data    raw PS/2 data pin (asynchronous)
//   nextdata_n  active-low pop request, level-sampled
//   clr_ovf     synchronous overflow clear pulse
//   data        FIFO head {ext, brk, scan[7:0]}, 0 when empty
//   ready       FIFO not empty
//   overflow    sticky event-dropped flag
//   level       number of stored events
//   frame_err   saturating count of rejected/timed-out frames
module ps2_scan_rx #(
  parameter int FIFO_AW    = 3,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 50000
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  input  logic               nextdata_n,
  input  logic               clr_ovf,
  output logic [9:0]         data,
  output logic               ready,
  output logic               overflow,
  output logic [FIFO_AW:0]   level,
  output logic [7:0]         frame_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [3:0]    FL_M1   = 4'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_lvl;
  logic [3:0]    filt_cnt;
  logic          strobe;

  logic [3:0]    bit_cnt;
  logic [9:0]    sr;
  logic [TW-1:0] to_cnt;

  logic          ext, brk;

  logic [9:0]    mem [DEPTH];
  logic [FIFO_AW:0] wptr, rptr;

  logic          frame_done, frame_ok, byte_ok, timeout, err_inc, emit;
  logic [7:0]    rx_byte;
  logic [9:0]    ev;
  logic          empty, full, pop, push_ok, drop;

  // Synchronisers and clock deglitch filter. The filtered level only flips
  // after FILTER_LEN consecutive samples that disagree with it.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      filt_lvl <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      if (clk_s2 != filt_lvl) begin
        if (filt_cnt == FL_M1) begin
          filt_lvl <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 4'd1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // Strobe fires on the edge where the filtered level falls, so the data bit
  // is captured on that same edge.
  assign strobe = filt_lvl & ~clk_s2 & (filt_cnt == FL_M1);

  assign rx_byte    = sr[8:1];
  assign frame_done = strobe && (bit_cnt == 4'd10);
  assign frame_ok   = ~sr[0] & dat_s2 & (^sr[9:1]);
  assign byte_ok    = frame_done & frame_ok;
  assign timeout    = ~strobe && (bit_cnt != 4'd0) && (to_cnt == '0);
  assign err_inc    = (frame_done & ~frame_ok) | timeout;
  assign emit       = byte_ok && (rx_byte != 8'hE0) && (rx_byte != 8'hF0);
  assign ev         = {ext, brk, rx_byte};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt   <= '0;
      sr        <= '0;
      to_cnt    <= TO_LOAD;
      ext       <= 1'b0;
      brk       <= 1'b0;
      frame_err <= '0;
    end else begin
      if (strobe) begin
        to_cnt <= TO_LOAD;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
        end else begin
          sr[bit_cnt] <= dat_s2;
          bit_cnt     <= bit_cnt + 4'd1;
        end
      end else begin
        if (to_cnt != '0) to_cnt <= to_cnt - TW'(1);
        if (timeout) bit_cnt <= '0;
      end

      if (byte_ok) begin
        if (rx_byte == 8'hE0) begin
          ext <= 1'b1;
        end else if (rx_byte == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end

      if (err_inc && frame_err != 8'hFF) frame_err <= frame_err + 8'd1;
    end
  end

  // FIFO: pointers carry a wrap bit so full and empty are distinguishable.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                   (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign pop     = ~nextdata_n & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = emit & (~full | pop);
  assign drop    = emit & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[FIFO_AW-1:0]] <= ev;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  assign ready = ~empty;
  assign level = wptr - rptr;
  assign data  = empty ? 10'd0 : mem[rptr[FIFO_AW-1:0]];

endmodule

// File: tb/tb_ps2_scan_rx.sv
module tb_ps2_scan_rx;

  localparam int FA = 3;
  localparam int FL = 4;
  localparam int TO = 300;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        nextdata_n = 1'b1;
  logic        clr_ovf = 1'b0;
  logic [9:0]  data;
  logic        ready;
  logic        overflow;
  logic [FA:0] level;
  logic [7:0]  frame_err;

  int checks = 0;
  int errors = 0;

  ps2_scan_rx #(.FIFO_AW(FA), .FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .clr_ovf(clr_ovf), .data(data), .ready(ready),
    .overflow(overflow), .level(level), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // start, 8 data bits LSB first, odd parity, stop
  function automatic logic [10:0] mk(input logic [7:0] b, input logic bad_par, input logic stop);
    logic par;
    par = (~^b) ^ bad_par;
    return {stop, par, b, 1'b0};
  endfunction

  task automatic send(input logic [10:0] f, input int nbits, input logic glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (10) @(negedge clk);
      ps2_clk = 1'b1;
      if (glitch && i == 4) begin
        repeat (3) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FL - 1) @(negedge clk);
        ps2_clk = 1'b1;
      end
      repeat (10) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic pop1();
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 16'(ready), 16'h0);
    check("rst_data", 16'(data), 16'h0);
    check("rst_ovf", 16'(overflow), 16'h0);
    check("rst_level", 16'(level), 16'h0);
    check("rst_ferr", 16'(frame_err), 16'h0);
    clrn = 1'b1;
    @(negedge clk);

    // single make code, then pop
    send(mk(8'h1C, 1'b0, 1'b1), 11, 1'b0);
    check("t1_ready", 16'(ready), 16'h1);
    check("t1_data", 16'(data), 16'h01C);
    check("t1_level", 16'(level), 16'h1);
    pop1();
    check("t1_pop_ready", 16'(ready), 16'h0);
    check("t1_pop_data", 16'(data), 16'h000);

    // extended break, then plain make
    send(mk(8'hE0, 1'b0, 1'b1), 11, 1'b0);
    send(mk(8'hF0, 1'b0, 1'b1), 11, 1'b0);
    check("t2_prefix_level", 16'(level), 16'h0);
    send(mk(8'h75, 1'b0, 1'b1), 11, 1'b0);
    check("t2_level", 16'(level), 16'h1);
    check("t2_data", 16'(data), 16'h375);
    pop1();
    send(mk(8'h75, 1'b0, 1'b1), 11, 1'b0);
    check("t2_data2", 16'(data), 16'h075);
    pop1();

    // bad parity, bad stop, then good frame
    send(mk(8'h1C, 1'b1, 1'b1), 11, 1'b0);
    send(mk(8'h1C, 1'b0, 1'b0), 11, 1'b0);
    check("t3_ferr", 16'(frame_err), 16'h2);
    check("t3_level", 16'(level), 16'h0);
    send(mk(8'h23, 1'b0, 1'b1), 11, 1'b0);
    check("t3_data", 16'(data), 16'h023);
    pop1();

    // overflow
    do_reset();
    for (int k = 1; k <= 9; k++) send(mk(8'(k), 1'b0, 1'b1), 11, 1'b0);
    check("t4_level", 16'(level), 16'h8);
    check("t4_ovf", 16'(overflow), 16'h1);
    check("t4_head", 16'(data), 16'h001);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("t4_ovf_clr", 16'(overflow), 16'h0);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("t4_pop%0d", k), 16'(data), 16'(k));
      pop1();
    end
    check("t4_empty", 16'(ready), 16'h0);
    check("t4_empty_level", 16'(level), 16'h0);

    // timeout
    do_reset();
    send(mk(8'h55, 1'b0, 1'b1), 5, 1'b0);
    repeat (TO + 10) @(negedge clk);
    check("t5_ferr", 16'(frame_err), 16'h1);
    check("t5_level", 16'(level), 16'h0);
    send(mk(8'h1C, 1'b0, 1'b1), 11, 1'b0);
    check("t5_data", 16'(data), 16'h01C);

    // deglitch: short low pulses on ps2_clk must not add strobes
    send(mk(8'h5A, 1'b0, 1'b1), 11, 1'b1);
    check("t6_glitch_level", 16'(level), 16'h2);
    check("t6_glitch_ferr", 16'(frame_err), 16'h1);
    pop1();
    check("t6_glitch_data", 16'(data), 16'h05A);

    // reset mid-frame after a pending E0 prefix
    send(mk(8'hE0, 1'b0, 1'b1), 11, 1'b0);
    send(mk(8'h1C, 1'b0, 1'b1), 5, 1'b0);
    #2 clrn = 1'b0;
    #1;
    check("t7_rst_ready", 16'(ready), 16'h0);
    check("t7_rst_data", 16'(data), 16'h0);
    check("t7_rst_level", 16'(level), 16'h0);
    check("t7_rst_ferr", 16'(frame_err), 16'h0);
    check("t7_rst_ovf", 16'(overflow), 16'h0);
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    send(mk(8'h1C, 1'b0, 1'b1), 11, 1'b0);
    check("t7_after_data", 16'(data), 16'h01C);
    check("t7_after_ferr", 16'(frame_err), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scan_rx.md
# ps2_scan_rx

Parametrised PS/2 keyboard receiver for the keyboard front end. It samples the PS/2 clock/data pair, validates each 11-bit frame and folds the E0/F0 prefix bytes into one event per key action. Events go into a FIFO of configurable depth, which the downstream consumer reads through a ready/nextdata_n handshake. Against the first-generation receiver, this block adds a deglitch filter, a frame timeout, prefix decoding, error counters and a clearable overflow flag.

## Interface
- FIFO_AW, default 3: FIFO address width; depth = 2^FIFO_AW entries.
- FILTER_LEN, default 4: consecutive equal samples of synchronised ps2_clk needed to change the filtered level; range 1–15.
- TIMEOUT, default 50000: clk cycles without a sample strobe before a partial frame is abandoned; must be ≥ 2.
- clk  in  1  system clock; the only clock.
- clrn  in  1  reset; asynchronous, active-low.
- ps2_clk  in  1  raw PS/2 clock, asynchronous to clk.
- ps2_data  in  1  raw PS/2 data, asynchronous to clk.
- nextdata_n  in  1  pop request, active-low, level-sampled each clk.
- clr_ovf  in  1  synchronous clear of overflow; 1-cycle pulse.
- data  out  10  FIFO head event: [9] ext (E0 seen), [8] brk (F0 seen), [7:0] scan code. Forced to 0 when ready=0.
- ready  out  1  FIFO not empty.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full.
- level  out  FIFO_AW+1  number of stored events.
- frame_err  out  8  saturating count of rejected frames (bad start, stop or parity, or timeout).

## Operation
- ps2_clk and ps2_data each pass through two flip-flops. A filter counter tracks synchronised ps2_clk; the filtered level flips after FILTER_LEN consecutive samples that differ from it. Strobe = 1-cycle pulse on a filtered 1→0 transition; ps2_data (synchronised) is captured at the strobe.
- Bit counter 0..10. Bit 0 = start, 1–8 = data LSB first, 9 = odd parity, 10 = stop.
  - Strobe at bit 10 closes the frame; the counter returns to 0.
  - The frame is valid iff start=0, stop=1 and the XOR of the 8 data bits and the parity bit = 1.
  - An invalid frame increments frame_err (saturates at 255) and produces no byte.
- Timeout: a down-counter reloads to TIMEOUT on every strobe. If the bit counter ≠ 0 and the down-counter reaches 0, the bit counter returns to 0 and frame_err increments. Timeout is inactive at bit 0.
- Prefix decoder (two flags, ext and brk), applied to each valid byte:
  - 0xE0 sets ext.
  - 0xF0 sets brk.
  - Any other byte emits the event {ext, brk, byte}, then both flags clear.
  - Prefix bytes never enter the FIFO.
  - A frame error or timeout does not clear the flags.
- FIFO: circular with a wrap bit, FIFO_AW-bit pointers plus a wrap bit.
  - Pop when nextdata_n=0 and ready=1; nextdata_n=0 while empty is ignored.
  - Push of an emitted event:
    - If not full, the event is stored.
    - If full and no pop this cycle, the event is dropped and overflow is set.
    - If full and a pop occurs the same cycle, the push is accepted.
  - If clr_ovf and a drop occur in the same cycle, overflow stays 1 (set wins).

## Timing
- Reset (clrn=0, asynchronous) sets:
  - ready=0, data=0, overflow=0, level=0, frame_err=0;
  - pointers, bit counter, prefix flags and filter state to 0;
  - filtered level and synchronisers to 1 (bus idle).
- Reset mid-frame discards the partial frame and any pending prefix.
- Latency from a falling edge on pin ps2_clk to the strobe: 2 + FILTER_LEN clk cycles (±1 for synchroniser metastability).
- On the stop-bit strobe, the frame check, decode and FIFO write all complete on that same clk edge. ready, level and data reflect the new entry from that edge.
- Pop: while nextdata_n=0 at edge N, the read pointer advances at N, and data shows the next entry (or 0 if the FIFO is now empty) after N.
  - Holding nextdata_n low pops once per cycle until empty.
  - Push and pop in the same cycle leave level unchanged.
- level updates on the same edge as the push or pop.

## Test plan
- Reset, then send frame 0x1C with correct parity → after the stop bit: ready=1, data=0x01C, level=1. Pulse nextdata_n low for one cycle → ready=0, data=0x000.
- Send bytes E0, F0, 75 → exactly one event, data=0x375. Then send 0x75 → second event data=0x075.
- Send 0x1C with bad parity, then a frame with stop=0 → frame_err=2, level=0. A following good 0x23 → data=0x023.
- With FIFO_AW=3 and no pops, send 9 make codes 0x01..0x09 → level=8, overflow=1, head=0x001. Pulse clr_ovf → overflow=0. Pop all 8 → events 0x001..0x008 in order.
- Send 5 bits of a frame, then idle TIMEOUT+10 cycles → frame_err=1. A following good 0x1C → data=0x01C.
- Inject ps2_clk low glitches of FILTER_LEN−1 cycles mid-frame → no extra strobes, byte received correctly. Assert clrn mid-frame → all outputs at reset values immediately.
